// File: rtl/cache_pkg.sv
// Shared definitions for the cache DRE maintenance controller:
// command encodings, FSM state codes and DRE geometry.
package cache_pkg;

   // Command opcodes presented on cmd_op
   localparam logic [1:0] CMD_NOP   = 2'd0;
   localparam logic [1:0] CMD_FLUSH = 2'd1;
   localparam logic [1:0] CMD_INV   = 2'd2;
   localparam logic [1:0] CMD_READ  = 2'd3;

   // Number of byte lanes (ways) per DRE row
   localparam int DRE_CHANNELS = 4;

   // Controller FSM state codes
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_CLR_ALL = 3'd1;
   localparam state_t ST_INV     = 3'd2;
   localparam state_t ST_RD_ADDR = 3'd3;
   localparam state_t ST_RD_DATA = 3'd4;

   // The controller owns the DRE RAM in every state except IDLE
   function automatic logic state_owns_ram(input state_t s);
      return (s != ST_IDLE);
   endfunction

endpackage

// File: rtl/cache_dre_ctrl_if.sv
// Bundle of the command/response handshake and the DRE "ri" port.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both 1. cmd_op/cmd_addr/cmd_ch must be stable while
// cmd_valid is 1. cmd_valid while cmd_ready is 0 is not queued: the request
// is simply seen again once cmd_ready returns. done and rsp_valid are
// single-cycle pulses with no backpressure.
interface cache_dre_ctrl_if #(
   parameter int ADDR_WIDTH = 8
);
   import cache_pkg::*;

   // command side
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [1:0]            cmd_op;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [1:0]            cmd_ch;
   logic                  done;
   logic                  rsp_valid;
   logic [7:0]            rsp_data;
   logic                  init_done;

   // DRE wrapper ri side
   logic                  sel;
   logic [ADDR_WIDTH:0]   ri_readAddress;
   logic [1:0]            ri_readChannel;
   logic [7:0]            ri_readData;
   logic [ADDR_WIDTH-1:0] ri_writeAddress;
   logic [1:0]            ri_writeChannel;
   logic                  ri_writeEnable;
   logic [7:0]            ri_writeData;

   // debug visibility of the FSM state
   state_t                dbg_state;

   // controller view
   modport slave (
      input  cmd_valid, cmd_op, cmd_addr, cmd_ch, ri_readData,
      output cmd_ready, done, rsp_valid, rsp_data, init_done,
      output sel, ri_readAddress, ri_readChannel,
      output ri_writeAddress, ri_writeChannel, ri_writeEnable, ri_writeData,
      output dbg_state
   );

   // cache FSM + DRE RAM view
   modport master (
      output cmd_valid, cmd_op, cmd_addr, cmd_ch, ri_readData,
      input  cmd_ready, done, rsp_valid, rsp_data, init_done,
      input  sel, ri_readAddress, ri_readChannel,
      input  ri_writeAddress, ri_writeChannel, ri_writeEnable, ri_writeData,
      input  dbg_state
   );

endinterface

// File: rtl/cache_dre_ctrl.sv
// Maintenance controller for the cache DRE RAM. Sweeps the whole RAM to
// CLEAR_VALUE after reset and on FLUSH_ALL, and services single-entry
// INVALIDATE and READ commands through the ri port of the DRE wrapper.
module cache_dre_ctrl
   import cache_pkg::*;
#(
   parameter int         ADDR_WIDTH  = 8,
   parameter logic [7:0] CLEAR_VALUE = 8'h00
) (
   input logic             clk,
   input logic             rst,
   cache_dre_ctrl_if.slave bus
);

   localparam int               ROW_W    = ADDR_WIDTH - 1;
   localparam logic [ROW_W-1:0] ROW_LAST = {ROW_W{1'b1}};
   localparam logic [1:0]       CH_LAST  = 2'(DRE_CHANNELS - 1);

   state_t                r_state;
   logic [ROW_W-1:0]      r_row;
   logic [1:0]            r_ch;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [1:0]            r_cmd_ch;
   logic                  r_init_done;
   logic                  r_rsp_valid;
   logic [7:0]            r_rsp_data;

   logic                  w_accept;
   logic                  w_in_clr;
   logic                  w_in_inv;
   logic                  w_in_rd;
   logic                  w_clr_last;

   assign w_accept   = (r_state == ST_IDLE) && bus.cmd_valid;
   assign w_in_clr   = (r_state == ST_CLR_ALL);
   assign w_in_inv   = (r_state == ST_INV);
   assign w_in_rd    = (r_state == ST_RD_ADDR) || (r_state == ST_RD_DATA);
   // final write of a sweep: last row, last lane
   assign w_clr_last = w_in_clr && (r_row == ROW_LAST) && (r_ch == CH_LAST);

   // Main FSM with the sweep row/lane counters and the latched command fields
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_CLR_ALL;
         r_row    <= '0;
         r_ch     <= '0;
         r_addr   <= '0;
         r_cmd_ch <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_addr   <= bus.cmd_addr;
                  r_cmd_ch <= bus.cmd_ch;
                  case (bus.cmd_op)
                     CMD_FLUSH: begin
                        r_row   <= '0;
                        r_ch    <= '0;
                        r_state <= ST_CLR_ALL;
                     end
                     CMD_INV:  r_state <= ST_INV;
                     CMD_READ: r_state <= ST_RD_ADDR;
                     // reserved opcode: consumed, no action
                     default:  r_state <= ST_IDLE;
                  endcase
               end
            end
            ST_CLR_ALL: begin
               // lane counter runs fastest; row advances when the lane wraps
               r_ch <= r_ch + 2'd1;
               if (r_ch == CH_LAST) begin
                  r_row <= r_row + ROW_W'(1);
               end
               if (w_clr_last) begin
                  r_state <= ST_IDLE;
               end
            end
            ST_INV:     r_state <= ST_IDLE;
            ST_RD_ADDR: r_state <= ST_RD_DATA;
            ST_RD_DATA: r_state <= ST_IDLE;
            default:    r_state <= ST_IDLE;
         endcase
      end
   end

   // init_done rises at the end of the first sweep and only reset clears it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_init_done <= 1'b0;
      end else if (w_clr_last) begin
         r_init_done <= 1'b1;
      end
   end

   // Capture RAM read data in RD_DATA; publish it as a one-cycle response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
      end else begin
         r_rsp_valid <= (r_state == ST_RD_DATA);
         if (r_state == ST_RD_DATA) begin
            r_rsp_data <= bus.ri_readData;
         end
      end
   end

   // Combinational ri-port drive from state; write strobe and done are
   // forced low while reset is held even though the reset state is CLR_ALL
   always_comb begin
      bus.ri_writeEnable  = 1'b0;
      bus.ri_writeAddress = '0;
      bus.ri_writeChannel = '0;
      bus.ri_readAddress  = '0;
      bus.ri_readChannel  = '0;
      bus.done            = 1'b0;
      if (!rst) begin
         if (w_in_clr) begin
            bus.ri_writeEnable  = 1'b1;
            bus.ri_writeAddress = {r_row, 1'b0};
            bus.ri_writeChannel = r_ch;
         end else if (w_in_inv) begin
            bus.ri_writeEnable  = 1'b1;
            bus.ri_writeAddress = {r_addr[ADDR_WIDTH-1:1], 1'b0};
            bus.ri_writeChannel = r_cmd_ch;
         end
         if (w_in_rd) begin
            bus.ri_readAddress = {r_addr, 1'b0};
            bus.ri_readChannel = r_cmd_ch;
         end
         bus.done = w_clr_last || w_in_inv;
      end
   end

   assign bus.sel          = state_owns_ram(r_state);
   assign bus.cmd_ready    = (r_state == ST_IDLE);
   assign bus.ri_writeData = CLEAR_VALUE;
   assign bus.rsp_valid    = r_rsp_valid;
   assign bus.rsp_data     = r_rsp_data;
   assign bus.init_done    = r_init_done;
   assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_cache_dre_ctrl.sv
// Bench for cache_dre_ctrl with ADDR_WIDTH=4 (8 rows x 4 lanes).
// The bench plays both the cache FSM and the DRE RAM.
module tb_cache_dre_ctrl;
   import cache_pkg::*;

   localparam int         AW   = 4;
   localparam int         ROWS = 8;
   localparam int         NWR  = 32;
   localparam logic [7:0] CLR  = 8'h00;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cache_dre_ctrl_if #(.ADDR_WIDTH(AW)) bus();

   cache_dre_ctrl #(.ADDR_WIDTH(AW), .CLEAR_VALUE(CLR)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // DRE RAM: write on the clock edge, read data registered one cycle later
   logic [7:0] ram [ROWS][4];
   logic [7:0] rd_q;
   logic       pre_fill = 1'b0;
   logic       pre_we   = 1'b0;
   logic [2:0] pre_row  = '0;
   logic [1:0] pre_ch   = '0;
   logic [7:0] pre_data = '0;

   always @(posedge clk) begin
      if (pre_fill) begin
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < 4; c++)
               ram[r][c] <= pre_data;
      end else if (pre_we) begin
         ram[pre_row][pre_ch] <= pre_data;
      end
      if (bus.ri_writeEnable)
         ram[bus.ri_writeAddress[AW-1:1]][bus.ri_writeChannel] <= bus.ri_writeData;
      rd_q <= ram[bus.ri_readAddress[AW:2]][bus.ri_readChannel];
   end
   assign bus.ri_readData = rd_q;

   // reference contents of the DRE as the commands should leave it
   logic [7:0] exp_mem [ROWS][4];

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [1:0] op;
      logic [3:0] addr;
      logic [1:0] ch;
      logic       sel1;   // n+1 values
      logic       we1;
      logic [3:0] wa1;
      logic [1:0] wch1;
      logic       done1;
      logic [4:0] ra1;
      logic       ready2; // n+2
      logic       rsp3;   // n+3
   } vec_t;
   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input int row, input int ch, input logic [7:0] d);
      pre_row  = 3'(row);
      pre_ch   = 2'(ch);
      pre_data = d;
      pre_we   = 1'b1;
      step();
      pre_we   = 1'b0;
      exp_mem[row][ch] = d;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!bus.cmd_ready && n < 64) begin
         step();
         n++;
      end
      chk("cmd_ready_before_issue", bus.cmd_ready, 1);
   endtask

   // entered in the first write cycle of a sweep; leaves in the cycle after done
   task automatic check_sweep(input string tag, input logic init_before);
      for (int i = 0; i < NWR; i++) begin
         chk({tag, "_sel"},   bus.sel, 1);
         chk({tag, "_we"},    bus.ri_writeEnable, 1);
         chk({tag, "_waddr"}, bus.ri_writeAddress, (i / 4) * 2);
         chk({tag, "_wch"},   bus.ri_writeChannel, i % 4);
         chk({tag, "_wdata"}, bus.ri_writeData, CLR);
         chk({tag, "_ready"}, bus.cmd_ready, 0);
         chk({tag, "_done"},  bus.done, (i == NWR - 1) ? 1 : 0);
         chk({tag, "_init"},  bus.init_done, init_before);
         step();
      end
      chk({tag, "_end_sel"},   bus.sel, 0);
      chk({tag, "_end_ready"}, bus.cmd_ready, 1);
      chk({tag, "_end_done"},  bus.done, 0);
      chk({tag, "_end_we"},    bus.ri_writeEnable, 0);
      chk({tag, "_end_init"},  bus.init_done, 1);
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < 4; c++) begin
            exp_mem[r][c] = CLR;
            chk({tag, "_ram"}, ram[r][c], exp_mem[r][c]);
         end
   endtask

   // issue one command and check it against the documented latencies
   task automatic run_cmd(input logic [1:0] op, input logic [3:0] addr, input logic [1:0] ch);
      int row;
      row = int'(addr) / 2;
      wait_ready();
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_addr  = addr;
      bus.cmd_ch    = ch;
      step();
      bus.cmd_valid = 1'b0;
      case (op)
         CMD_FLUSH: check_sweep("flush", 1'b1);
         CMD_INV: begin
            chk("inv_sel",   bus.sel, 1);
            chk("inv_we",    bus.ri_writeEnable, 1);
            chk("inv_waddr", bus.ri_writeAddress, row * 2);
            chk("inv_wch",   bus.ri_writeChannel, ch);
            chk("inv_wdata", bus.ri_writeData, CLR);
            chk("inv_done",  bus.done, 1);
            chk("inv_ready", bus.cmd_ready, 0);
            exp_mem[row][ch] = CLR;
            step();
            chk("inv_ready2", bus.cmd_ready, 1);
            chk("inv_done2",  bus.done, 0);
            chk("inv_we2",    bus.ri_writeEnable, 0);
            chk("inv_sel2",   bus.sel, 0);
         end
         CMD_READ: begin
            chk("rd_sel1",   bus.sel, 1);
            chk("rd_we1",    bus.ri_writeEnable, 0);
            chk("rd_raddr1", bus.ri_readAddress, int'(addr) * 2);
            chk("rd_rch1",   bus.ri_readChannel, ch);
            chk("rd_ready1", bus.cmd_ready, 0);
            chk("rd_done1",  bus.done, 0);
            step();
            chk("rd_sel2",   bus.sel, 1);
            chk("rd_raddr2", bus.ri_readAddress, int'(addr) * 2);
            chk("rd_rsp2",   bus.rsp_valid, 0);
            step();
            chk("rd_rsp3",   bus.rsp_valid, 1);
            chk("rd_data3",  bus.rsp_data, exp_mem[row][ch]);
            chk("rd_sel3",   bus.sel, 0);
            chk("rd_ready3", bus.cmd_ready, 1);
            step();
            chk("rd_rsp4",   bus.rsp_valid, 0);
         end
         default: begin
            chk("nop_ready", bus.cmd_ready, 1);
            chk("nop_we",    bus.ri_writeEnable, 0);
            chk("nop_done",  bus.done, 0);
            chk("nop_sel",   bus.sel, 0);
            step();
            chk("nop_rsp",   bus.rsp_valid, 0);
            chk("nop_done2", bus.done, 0);
         end
      endcase
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = CMD_NOP;
      bus.cmd_addr  = '0;
      bus.cmd_ch    = '0;

      //               op        addr  ch  sel we wa  wch done ra  rdy2 rsp3
      vecs[0] = '{CMD_NOP,   4'd5,  2'd1, 0, 0, 0,  0,  0,  0,  1, 0};
      vecs[1] = '{CMD_INV,   4'd11, 2'd1, 1, 1, 10, 1,  1,  0,  1, 0};
      vecs[2] = '{CMD_INV,   4'd0,  2'd0, 1, 1, 0,  0,  1,  0,  1, 0};
      vecs[3] = '{CMD_INV,   4'd15, 2'd3, 1, 1, 14, 3,  1,  0,  1, 0};
      vecs[4] = '{CMD_READ,  4'd10, 2'd2, 1, 0, 0,  0,  0,  20, 0, 1};
      vecs[5] = '{CMD_READ,  4'd7,  2'd3, 1, 0, 0,  0,  0,  14, 0, 1};
      vecs[6] = '{CMD_NOP,   4'd15, 2'd3, 0, 0, 0,  0,  0,  0,  1, 0};

      // 1: reset values, then the auto-clear over a RAM full of 8'hFF
      pre_data = 8'hFF;
      pre_fill = 1'b1;
      step();
      pre_fill = 1'b0;
      chk("rst_sel",       bus.sel, 1);
      chk("rst_ready",     bus.cmd_ready, 0);
      chk("rst_done",      bus.done, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_data",  bus.rsp_data, 0);
      chk("rst_init",      bus.init_done, 0);
      chk("rst_we",        bus.ri_writeEnable, 0);
      chk("rst_waddr",     bus.ri_writeAddress, 0);
      chk("rst_wch",       bus.ri_writeChannel, 0);
      chk("rst_raddr",     bus.ri_readAddress, 0);
      chk("rst_rch",       bus.ri_readChannel, 0);
      chk("rst_ram_ff",    ram[3][2], 8'hFF);
      rst = 1'b0;
      #1;
      check_sweep("autoclr", 1'b0);

      // 2: read back a preloaded byte
      preload(5, 2, 8'hA5);
      run_cmd(CMD_READ, 4'd10, 2'd2);

      // 3: invalidate one lane of row 5, other lanes untouched
      for (int c = 0; c < 4; c++) preload(5, c, 8'hFF);
      run_cmd(CMD_INV, 4'd11, 2'd1);
      for (int c = 0; c < 4; c++) run_cmd(CMD_READ, 4'd10, 2'(c));

      // table of single commands
      preload(5, 2, 8'h5A);
      preload(3, 3, 8'h3C);
      for (int i = 0; i < 7; i++) begin
         wait_ready();
         bus.cmd_valid = 1'b1;
         bus.cmd_op    = vecs[i].op;
         bus.cmd_addr  = vecs[i].addr;
         bus.cmd_ch    = vecs[i].ch;
         step();
         bus.cmd_valid = 1'b0;
         chk("vec_sel1",   bus.sel, vecs[i].sel1);
         chk("vec_we1",    bus.ri_writeEnable, vecs[i].we1);
         chk("vec_done1",  bus.done, vecs[i].done1);
         chk("vec_ready1", bus.cmd_ready, !vecs[i].sel1);
         if (vecs[i].we1) begin
            chk("vec_wa1",  bus.ri_writeAddress, vecs[i].wa1);
            chk("vec_wch1", bus.ri_writeChannel, vecs[i].wch1);
            exp_mem[vecs[i].addr / 2][vecs[i].ch] = CLR;
         end
         if (vecs[i].op == CMD_READ) chk("vec_ra1", bus.ri_readAddress, vecs[i].ra1);
         step();
         chk("vec_ready2", bus.cmd_ready, vecs[i].ready2);
         chk("vec_done2",  bus.done, 0);
         step();
         chk("vec_rsp3",   bus.rsp_valid, vecs[i].rsp3);
         if (vecs[i].op == CMD_READ)
            chk("vec_data3", bus.rsp_data, exp_mem[vecs[i].addr / 2][vecs[i].ch]);
      end

      // 4: flush while an INVALIDATE is held on the port
      preload(2, 1, 8'h3C);
      preload(7, 3, 8'hC3);
      wait_ready();
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = CMD_FLUSH;
      bus.cmd_addr  = 4'd0;
      bus.cmd_ch    = 2'd0;
      step();
      bus.cmd_op    = CMD_INV;
      bus.cmd_addr  = 4'd3;
      bus.cmd_ch    = 2'd3;
      #1;
      check_sweep("flush_held", 1'b1);
      step();
      bus.cmd_valid = 1'b0;
      chk("held_inv_we",    bus.ri_writeEnable, 1);
      chk("held_inv_waddr", bus.ri_writeAddress, 2);
      chk("held_inv_wch",   bus.ri_writeChannel, 3);
      chk("held_inv_done",  bus.done, 1);
      step();
      chk("held_inv_ready", bus.cmd_ready, 1);

      // 5: reset from IDLE, then again in the middle of the auto-clear
      preload(3, 2, 8'h77);
      rst = 1'b1;
      #1;
      chk("rst2_init",  bus.init_done, 0);
      chk("rst2_sel",   bus.sel, 1);
      chk("rst2_ready", bus.cmd_ready, 0);
      step();
      step();
      rst = 1'b0;
      #1;
      for (int i = 0; i < 13; i++) step();
      chk("mid_waddr", bus.ri_writeAddress, 6);
      chk("mid_wch",   bus.ri_writeChannel, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_sel",   bus.sel, 1);
      chk("mid_rst_we",    bus.ri_writeEnable, 0);
      chk("mid_rst_waddr", bus.ri_writeAddress, 0);
      chk("mid_rst_wch",   bus.ri_writeChannel, 0);
      chk("mid_rst_done",  bus.done, 0);
      chk("mid_rst_ready", bus.cmd_ready, 0);
      chk("mid_rst_init",  bus.init_done, 0);
      chk("mid_rst_rsp",   bus.rsp_valid, 0);
      step();
      step();
      rst = 1'b0;
      #1;
      check_sweep("restart", 1'b0);

      // 6 and random traffic against the contents model
      run_cmd(CMD_NOP, 4'd9, 2'd2);
      for (int k = 0; k < 40; k++) begin
         logic [1:0] op;
         op = 2'($urandom_range(0, 3));
         if (op == CMD_FLUSH && $urandom_range(0, 3) != 0) op = CMD_READ;
         if ($urandom_range(0, 2) == 0)
            preload($urandom_range(0, ROWS - 1), $urandom_range(0, 3), 8'($urandom_range(1, 255)));
         for (int g = $urandom_range(0, 2); g > 0; g--) step();
         run_cmd(op, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cache_dre_ctrl.md
Name: cache_dre_ctrl

Overview:
- Maintenance controller for the cache byte-readable-enable (DRE) RAM.
- Drives the "ri" side of the DRE wrapper: the `sel` mux select, the ri read/write address and channel, the write enable and the write data.
- Runs three jobs: the automatic clear after reset, a full flush, and single-entry invalidate/read commands issued by the cache control FSM.
- While it owns the RAM (`sel`=1), the normal read/write path is locked out.

Parameters:
- ADDR_WIDTH, 8, DRE address width. RAM rows = 2^(ADDR_WIDTH-1); write addresses use bit0=0.
- CLEAR_VALUE, 8'h00, byte written on flush/invalidate (all bytes not readable).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  controller idle, command accepted when valid&ready
- cmd_op  in  2  1=FLUSH_ALL, 2=INVALIDATE, 3=READ; 0 is reserved and is accepted and ignored
- cmd_addr  in  ADDR_WIDTH  entry address; bit0 is ignored for writes
- cmd_ch  in  2  channel (way)
- done  out  1  one-cycle pulse when a FLUSH_ALL, INVALIDATE or auto-clear completes
- rsp_valid  out  1  one-cycle pulse, READ data valid
- rsp_data  out  8  DRE byte read back
- init_done  out  1  sticky 1 after the first post-reset clear completes
- sel  out  1  1 = the ri path owns the DRE RAM
- ri_readAddress  out  ADDR_WIDTH+1  = {cmd_addr,1'b0} during READ
- ri_readChannel  out  2  read channel
- ri_readData  in  8  DRE read data, valid one cycle after the address is presented
- ri_writeAddress  out  ADDR_WIDTH  write address
- ri_writeChannel  out  2  write channel (byte lane)
- ri_writeEnable  out  1  write strobe
- ri_writeData  out  8  write data (CLEAR_VALUE)

Behaviour:
- Reset values:
  - state = CLR_ALL; row counter and channel counter = 0.
  - cmd_ready, done, rsp_valid, init_done = 0; rsp_data = 0.
  - ri_writeEnable = 0; all ri_* addresses and channels = 0.
  - `sel` is combinational from state, so it is 1 immediately in reset.
- States:
  - IDLE: `sel`=0, cmd_ready=1.
  - CLR_ALL: `sel`=1.
    - Each cycle writes CLEAR_VALUE at ri_writeAddress={row,1'b0}, ri_writeChannel=ch, ri_writeEnable=1.
    - ch increments 0..3, then wraps to 0 and row increments.
    - After row = 2^(ADDR_WIDTH-1)-1 with ch = 3: pulse done, set init_done, go to IDLE.
    - Duration is exactly 2^(ADDR_WIDTH+1) write cycles.
  - INV: one cycle, `sel`=1. Writes CLEAR_VALUE at ({cmd_addr[ADDR_WIDTH-1:1],1'b0}, cmd_ch) with ri_writeEnable=1, pulses done, then returns to IDLE.
  - RD_ADDR: `sel`=1, ri_readAddress={addr,1'b0}, ri_readChannel=ch; goes to RD_DATA.
  - RD_DATA: `sel`=1 with address held; register ri_readData into rsp_data; go to IDLE. rsp_valid=1 in the following cycle.
- Commands:
  - addr/ch are latched at acceptance.
  - Commands are accepted only in IDLE; cmd_ready=0 in every other state, including the auto-clear.
  - FLUSH_ALL resets both counters to 0 and enters CLR_ALL.
  - FLUSH_ALL does not clear init_done (it is already 1).
- Latency, cycle n = acceptance edge:
  - INVALIDATE: write in cycle n+1, done in n+1, cmd_ready=1 again in n+2.
  - READ: address in n+1, data sampled in n+2, rsp_valid/rsp_data in n+3, cmd_ready=1 in n+3.
  - FLUSH_ALL: first write in n+1, done in the last write cycle.
- Outputs outside write states: ri_writeEnable=0; ri_writeData is always CLEAR_VALUE.
- done and rsp_valid are single-cycle pulses with no backpressure.
- Reset asserted mid-operation: reset aborts any state. After release, a full auto-clear restarts from row 0, ch 0, and init_done drops to 0 until it completes.
- cmd_valid during reset or busy states is ignored, not queued.

Decomposition:
- Shared package `cache_pkg`:
  - cmd_op encodings CMD_NOP/CMD_FLUSH/CMD_INV/CMD_READ.
  - State enum.
  - DRE_CHANNELS=4.
- No sub-module: a single FSM with counters.

Test Plan:
1. ADDR_WIDTH=4, pre-load the RAM model with 8'hFF, release rst
   - `sel`=1 for exactly 32 cycles; writes cover rows 0..7 × ch 0..3, each with data 8'h00.
   - done pulses on the 32nd write; init_done=1; cmd_ready=1 on the next cycle.
2. After init, pre-load row 5 ch 2 with 8'hA5; issue READ addr=10 ch=2
   - ri_readAddress=21'b... {10,0}=20 in n+1.
   - rsp_valid=1 with rsp_data=8'hA5 in n+3, with `sel`=1 only in n+1..n+2.
3. INVALIDATE addr=11 ch=1 (RAM row 5 = 8'hFF)
   - Single write at ri_writeAddress=10, ch 1, data 8'h00 in n+1; done in n+1.
   - A subsequent READ returns 8'h00; the other channels are unchanged.
4. Issue FLUSH_ALL, and hold cmd_valid with INVALIDATE during the flush
   - cmd_ready stays 0 for 32 cycles and the INVALIDATE is ignored.
   - The INVALIDATE is accepted the first cycle after done.
5. Assert rst at write 13 of the auto-clear, release it 2 cycles later
   - Outputs go to reset values immediately; the sweep restarts at row 0 ch 0 and completes all 32 writes.
6. cmd_op=0 accepted in IDLE
   - No write, no done, no rsp_valid; cmd_ready stays 1.
